led_pio_sequencer: RTL and testbench
====================================

# led_pio_sequencer

Hardware pattern sequencer that drives the 8-bit LED PIO slave on the CPU's behalf. The CPU loads up to eight LED patterns, a dwell period and a step count through an Avalon-MM slave, then sets `run`. The block acts as the sole Avalon-MM master of the PIO `s1` port, writing each pattern in turn with exact cycle timing, in one-shot or loop mode, and raises an interrupt on completion.

## Interface

Parameters:
- `NUM_STEPS`, 8: pattern slots; a power of two, at most 8.
- `LED_W`, 8: pattern width; matches PIO `out_port`.
- `PRESCALE_W`, 24: width of the dwell counter.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `address` in 4: slave word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: slave write strobe, active-low.
- `writedata` in 32: slave write data.
- `readdata` out 32: slave read data, combinational, zero wait states.
- `m_address` out 2: master address to PIO; always 0.
- `m_chipselect` out 1: master select to PIO.
- `m_write_n` out 1: master write strobe to PIO, active-low.
- `m_writedata` out 32: `{24'b0, pattern}`.
- `irq` out 1: `done & irq_en`.

## Operation

Register map (word addresses):
- 0 CTRL, R/W:
  - bit0 `run`: 0→1 while idle starts a sequence; cleared by hardware at one-shot completion.
  - bit1 `loop`.
  - bit2 `irq_en`.
- 1 STATUS, R:
  - bit0 `busy`.
  - bit1 `done`: write 1 to clear.
  - bits[6:4] current step index.
- 2 PERIOD, R/W, [PRESCALE_W-1:0]: dwell of PERIOD+1 cycles per step.
- 3 LENGTH, R/W, [2:0]: last step index. LENGTH=0 means one step.
- 8..15 PATTERN[0..7], R/W, [7:0].
- Unmapped addresses read 0; writes to them are ignored.

FSM states:
- IDLE: master outputs are inactive. On `run` 0→1: idx←0, `done`←0, go to WRITE.
- WRITE: lasts exactly one cycle. `m_chipselect`=1, `m_write_n`=0, `m_writedata`={24'b0, PATTERN[idx]}. Load dwell counter←PERIOD. Go to DWELL.
- DWELL: decrement each cycle. On the cycle the counter is 0:
  - If idx≥LENGTH and `loop`=1: idx←0, go to WRITE.
  - If idx≥LENGTH and `loop`=0: `done`←1, `run`←0, go to IDLE.
  - Otherwise: idx←idx+1, go to WRITE.
- Any state with `run` written 0: go to IDLE on the next edge. No further master write occurs, and the PIO keeps its last pattern. idx holds its value.

Boundary rules:
- `run`=1 written while busy: no restart. Only `loop` and `irq_en` update.
- PATTERN written during a run: the new value is sampled only at that slot's next WRITE.
- PERIOD written mid-dwell: applies from the next WRITE.
- LENGTH lowered below the current idx: the current step becomes the last step (≥ compare).
- `done` W1C in the same cycle hardware sets it: set wins.
- Reset: all registers 0, FSM IDLE, `readdata`=0, `m_chipselect`=0, `m_write_n`=1, `m_writedata`=0, `m_address`=0, `irq`=0.

## Timing

- Slave writes take effect at the next `clk` edge. Reads are combinational from `address`.
- `run` written at edge N: WRITE strobe asserted in cycle N+1, PIO `out_port` updates at edge N+2.
- Master strobe to next strobe: PERIOD+2 cycles (1 WRITE + PERIOD+1 DWELL). With PERIOD=0 the period is 2 cycles.
- One-shot: `done`/`irq` rise at the edge ending the last DWELL, PERIOD+2 cycles after the last strobe's cycle start.
- `busy` = (state≠IDLE).
- The PIO has no waitrequest, so every master write completes in its strobe cycle.

## Structure

- Package `led_seq_pkg`:
  - state enum `{IDLE, WRITE, DWELL}`.
  - register address constants.
  - CTRL/STATUS bit positions.
- Sub-module `led_seq_prescaler`: PRESCALE_W down-counter with `load`, `load_val` and `zero` output.
- PATTERN storage is a flop array, not RAM, so it can be read combinationally.

## Test plan

- Reset → all master outputs inactive, `readdata`=0 for every address, `irq`=0.
- PATTERN[0..2]=0x01,0x02,0x04, LENGTH=2, PERIOD=3, `run`=1, loop=0 → three strobes 5 cycles apart with data 1,2,4. `done`=1 and `run`=0 5 cycles after the third strobe, then no further strobes.
- Same setup with loop=1 → strobe data sequence 1,2,4,1,2,4 at a constant 5-cycle spacing. Writing `run`=0 mid-dwell → no strobes after, `busy`=0 next cycle, PIO keeps its last value.
- PERIOD=0, LENGTH=0, PATTERN[0]=0xA5, one-shot, irq_en=1 → single strobe with data 0x000000A5. `irq`=1 2 cycles later; writing STATUS with 0x2 clears `irq` next edge.
- During a loop run, overwrite PATTERN[1]=0xFF while idx=1 is dwelling → the current step keeps the old value and the next pass writes 0xFF. Set LENGTH=0 while idx=1 → the run wraps or ends after the current dwell.
- `run` rewritten to 1 while busy → no restart and idx keeps advancing. A simultaneous `done` set and W1C → `done` reads 1.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and register map for the LED PIO pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DWELL} state_e;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_STATUS   = 4'd1;
  localparam logic [3:0] ADDR_PERIOD   = 4'd2;
  localparam logic [3:0] ADDR_LENGTH   = 4'd3;
  localparam logic [3:0] ADDR_PATTERN0 = 4'd8;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_LOOP    = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 4;

  localparam int IDX_W        = 3;

endpackage

// File: rtl/led_pio_sequencer_if.sv
// CPU-facing Avalon-MM slave bus, PIO-facing master bus and irq, bundled.
interface led_pio_sequencer_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        irq;

  // sequencer side
  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );

  // CPU / system side
  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );
endinterface

// File: rtl/led_seq_prescaler.sv
// Dwell down-counter: load sets the count, then it decrements and parks at zero.
module led_seq_prescaler #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/led_pio_sequencer.sv
// Plays up to NUM_STEPS LED patterns into the PIO s1 port with fixed dwell,
// one-shot or looping, under control of a small Avalon-MM register file.
module led_pio_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_STEPS  = 8,
  parameter int LED_W      = 8,
  parameter int PRESCALE_W = 24
) (
  input logic                clk,
  input logic                reset_n,
  led_pio_sequencer_if.slave bus
);

  localparam int SLOT_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             run_q, loop_q, irq_en_q, done_q;
  logic [PRESCALE_W-1:0]            period_q;
  logic [IDX_W-1:0]                 length_q;
  logic [NUM_STEPS-1:0][LED_W-1:0]  pattern_q;

  logic wr_en, ctrl_wr, status_wr, period_wr, length_wr, pat_sel;
  logic run_start, run_stop, last_step, cnt_zero, seq_end, strobe;
  logic [SLOT_W-1:0] pat_slot;
  logic unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign ctrl_wr   = wr_en && (bus.address == ADDR_CTRL);
  assign status_wr = wr_en && (bus.address == ADDR_STATUS);
  assign period_wr = wr_en && (bus.address == ADDR_PERIOD);
  assign length_wr = wr_en && (bus.address == ADDR_LENGTH);
  assign pat_sel   = (bus.address >= ADDR_PATTERN0) && (int'(bus.address[2:0]) < NUM_STEPS);
  assign pat_slot  = bus.address[SLOT_W-1:0];
  assign unused_wd = ^bus.writedata;

  assign run_start = ctrl_wr && bus.writedata[CTRL_RUN] && (state_q == IDLE);
  assign run_stop  = ctrl_wr && !bus.writedata[CTRL_RUN];
  // >= so that lowering LENGTH below idx ends the pass after the current step
  assign last_step = (idx_q >= length_q) || (int'(idx_q) == NUM_STEPS - 1);
  assign strobe    = (state_q == WRITE);

  led_seq_prescaler #(.W(PRESCALE_W)) u_presc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (strobe),
    .load_val (period_q),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_end = 1'b0;
    unique case (state_q)
      IDLE: if (run_start) begin
        idx_d   = '0;
        state_d = WRITE;
      end
      WRITE: state_d = DWELL;
      DWELL: if (cnt_zero) begin
        if (last_step) begin
          if (loop_q) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            seq_end = 1'b1;
            state_d = IDLE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a software stop freezes idx and suppresses completion
    if (run_stop) begin
      state_d = IDLE;
      idx_d   = idx_q;
      seq_end = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      length_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (ctrl_wr) begin
        loop_q   <= bus.writedata[CTRL_LOOP];
        irq_en_q <= bus.writedata[CTRL_IRQ_EN];
        if (!bus.writedata[CTRL_RUN])  run_q <= 1'b0;
        else if (state_q == IDLE)      run_q <= 1'b1;
      end
      if (seq_end) run_q <= 1'b0;
      if (run_start)                                    done_q <= 1'b0;
      else if (seq_end)                                 done_q <= 1'b1;
      else if (status_wr && bus.writedata[STAT_DONE])   done_q <= 1'b0;
      if (period_wr) period_q <= bus.writedata[PRESCALE_W-1:0];
      if (length_wr) length_q <= bus.writedata[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                pattern_q           <= '0;
    else if (wr_en && pat_sel)   pattern_q[pat_slot] <= bus.writedata[LED_W-1:0];
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_CTRL: begin
        bus.readdata[CTRL_RUN]    = run_q;
        bus.readdata[CTRL_LOOP]   = loop_q;
        bus.readdata[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_STATUS: begin
        bus.readdata[STAT_BUSY]                   = (state_q != IDLE);
        bus.readdata[STAT_DONE]                   = done_q;
        bus.readdata[STAT_IDX_LSB +: IDX_W]       = idx_q;
      end
      ADDR_PERIOD: bus.readdata[PRESCALE_W-1:0] = period_q;
      ADDR_LENGTH: bus.readdata[IDX_W-1:0]      = length_q;
      default: if (pat_sel) bus.readdata[LED_W-1:0] = pattern_q[pat_slot];
    endcase
  end

  always_comb begin
    bus.m_writedata = '0;
    if (strobe) bus.m_writedata[LED_W-1:0] = pattern_q[idx_q[SLOT_W-1:0]];
  end

  assign bus.m_address    = '0;
  assign bus.m_chipselect = strobe;
  assign bus.m_write_n    = ~strobe;
  assign bus.irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed bench: register access, one-shot, loop, stop, irq and boundary cases.
module tb_led_pio_sequencer;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_pio_sequencer_if bus();

  led_pio_sequencer #(.NUM_STEPS(8), .LED_W(8), .PRESCALE_W(24)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int bad_addr = 0;
  int stb_cyc[$];
  logic [31:0] stb_dat[$];
  logic [7:0] pio = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.m_chipselect && !bus.m_write_n) pio <= bus.m_writedata[7:0];
  always @(negedge clk)
    if (bus.m_chipselect && !bus.m_write_n) begin
      stb_cyc.push_back(cyc);
      stb_dat.push_back(bus.m_writedata);
      if (bus.m_address != 2'd0) bad_addr++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.address = a; #1;
    d = bus.readdata;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic chk_strobes(input string tag, input int base, input int n,
                             input logic [31:0] exp_dat [8]);
    chk({tag, "_count"}, 32'(stb_cyc.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cyc"}, (i < stb_cyc.size()) ? 32'(stb_cyc[i]) : 32'hFFFF_FFFF, 32'(base + 5 * i));
      chk({tag, "_dat"}, (i < stb_dat.size()) ? stb_dat[i] : 32'hDEAD_BEEF, exp_dat[i]);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_dat [8];
    int e, f, g, h, j, k;

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_cs",  32'(bus.m_chipselect), 32'd0);
    chk("rst_m_wn",  32'(bus.m_write_n),    32'd1);
    chk("rst_m_wd",  bus.m_writedata,       32'd0);
    chk("rst_m_adr", 32'(bus.m_address),    32'd0);
    chk("rst_irq",   32'(bus.irq),          32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      chk("rst_rdata", d, 32'd0);
    end

    // register widths and unmapped space
    wr(ADDR_PERIOD, 32'hFFFF_FFFF); rd(ADDR_PERIOD, d); chk("period_w", d, 32'h00FF_FFFF);
    wr(ADDR_LENGTH, 32'hFFFF_FFFF); rd(ADDR_LENGTH, d); chk("length_w", d, 32'h0000_0007);
    wr(4'd4, 32'hFFFF_FFFF);        rd(4'd4, d);        chk("unmapped", d, 32'h0);
    wr(4'd8, 32'h1); wr(4'd9, 32'hFFFF_FF02); wr(4'd10, 32'h4);
    rd(4'd9, d); chk("pat_w", d, 32'h2);

    // one-shot, PERIOD=3, three steps
    wr(ADDR_PERIOD, 32'd3); wr(ADDR_LENGTH, 32'd2);
    stb_cyc.delete(); stb_dat.delete();
    wr(ADDR_CTRL, 32'h1); e = cyc;
    rd(ADDR_STATUS, d); chk("os_busy0", d, 32'h01);
    wait_until(e + 14); rd(ADDR_STATUS, d); chk("os_pre_done", d, 32'h21);
    wait_until(e + 15); rd(ADDR_STATUS, d); chk("os_done", d, 32'h22);
    rd(ADDR_CTRL, d); chk("os_run_clr", d, 32'h0);
    wait_until(e + 30);
    exp_dat = '{32'h1, 32'h2, 32'h4, 0, 0, 0, 0, 0};
    chk_strobes("os", e, 3, exp_dat);

    // loop, then stop mid-dwell of sixth step
    stb_cyc.delete(); stb_dat.delete();
    wr(ADDR_CTRL, 32'h3); f = cyc;
    wait_until(f + 27);
    wr(ADDR_CTRL, 32'h2); g = cyc;
    rd(ADDR_STATUS, d); chk("lp_stop", d, 32'h20);
    wait_until(g + 20);
    exp_dat = '{32'h1, 32'h2, 32'h4, 32'h1, 32'h2, 32'h4, 0, 0};
    chk_strobes("lp", f, 6, exp_dat);
    chk("lp_pio_hold", 32'(pio), 32'h4);

    // single step, PERIOD=0, irq
    wr(ADDR_PERIOD, 32'd0); wr(ADDR_LENGTH, 32'd0); wr(4'd8, 32'hA5);
    stb_cyc.delete(); stb_dat.delete();
    wr(ADDR_CTRL, 32'h5); h = cyc;
    chk("irq_h0", 32'(bus.irq), 32'd0);
    wait_until(h + 1); chk("irq_h1", 32'(bus.irq), 32'd0);
    wait_until(h + 2); chk("irq_h2", 32'(bus.irq), 32'd1);
    rd(ADDR_STATUS, d); chk("irq_status", d, 32'h02);
    wr(ADDR_STATUS, 32'h2);
    chk("irq_clr", 32'(bus.irq), 32'd0);
    rd(ADDR_STATUS, d); chk("w1c_status", d, 32'h00);
    wait_until(h + 10);
    exp_dat = '{32'hA5, 0, 0, 0, 0, 0, 0, 0};
    chk_strobes("one", h, 1, exp_dat);

    // pattern overwrite, run rewrite and LENGTH lowered during a loop run
    wr(4'd8, 32'h1); wr(ADDR_PERIOD, 32'd3); wr(ADDR_LENGTH, 32'd2);
    stb_cyc.delete(); stb_dat.delete();
    wr(ADDR_CTRL, 32'h3); j = cyc;
    wait_until(j + 6);
    wr(4'd9, 32'hFF);
    wr(ADDR_CTRL, 32'h3);
    rd(ADDR_STATUS, d); chk("bd_idx1", d, 32'h11);
    wait_until(j + 21);
    wr(ADDR_LENGTH, 32'd0);
    wait_until(j + 31);
    exp_dat = '{32'h1, 32'h2, 32'h4, 32'h1, 32'hFF, 32'h1, 32'h1, 0};
    chk_strobes("bd", j, 7, exp_dat);
    wr(ADDR_CTRL, 32'h0);

    // done set and W1C on the same edge
    wr(ADDR_PERIOD, 32'd0);
    wr(ADDR_CTRL, 32'h5); k = cyc;
    wait_until(k + 1);
    wr(ADDR_STATUS, 32'h2);
    rd(ADDR_STATUS, d); chk("set_wins", d, 32'h02);
    chk("set_wins_irq", 32'(bus.irq), 32'd1);

    chk("m_address", 32'(bad_addr), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
